// File: rtl/idma_pkg.sv
// -----------------------------------------------------------------------------
// idma_pkg
//   Shared types for the iDMA read-side burst tracker.
//   - axi_len_t       : AXI burst length (beats - 1), 8 bits.
//   - r_track_entry_t : per-burst record kept by the tracker {len, decoupled}.
//   - fifo_cnt_width  : helper giving the occupancy counter width for a depth.
// -----------------------------------------------------------------------------
package idma_pkg;

    typedef logic [7:0] axi_len_t;

    typedef struct packed {
        axi_len_t len;
        logic     decoupled;
    } r_track_entry_t;

    localparam int unsigned RTrackEntryW = $bits(r_track_entry_t);

    // Occupancy counter must be able to hold the value "depth" itself.
    function automatic int unsigned fifo_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/idma_stream_fifo.sv
// -----------------------------------------------------------------------------
// idma_stream_fifo
//   Small register-based FIFO with stream (valid/ready) ports and a
//   combinational head output, used as the per-burst entry store.
//
//   Parameters:
//     Depth     : number of entries (>= 2, need not be a power of two)
//     DataW     : entry width in bits
//     PrintInfo : report the configuration at elaboration
//
//   Ports:
//     clk_i      : clock, rising edge
//     rst_i      : asynchronous active-high reset
//     flush_i    : synchronous clear of all entries
//     testmode_i : test mode (no effect on this register implementation)
//     data_i     : entry to push
//     valid_i    : push request, accepted when ready_o is high
//     ready_o    : store is not full
//     data_o     : head entry (valid only while valid_o is high)
//     valid_o    : store is not empty
//     ready_i    : pop request, taken when valid_o is high
// -----------------------------------------------------------------------------
module idma_stream_fifo
    import idma_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataW     = 1,
    parameter bit          PrintInfo = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             testmode_i,
    input  logic [DataW-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [DataW-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = fifo_cnt_width(Depth);

    if (PrintInfo) begin : g_print_info
        $info("idma_stream_fifo: Depth=%0d DataW=%0d", Depth, DataW);
    end

    logic [DataW-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_unused_testmode;

    assign w_unused_testmode = testmode_i;

    assign w_full  = (r_count == CntW'(Depth));
    assign w_empty = (r_count == '0);
    assign w_push  = valid_i & ~w_full;
    assign w_pop   = ready_i & ~w_empty;

    assign ready_o = ~w_full;
    assign valid_o = ~w_empty;
    assign data_o  = r_mem[r_rptr];

    // Each slot captures data only when the write pointer selects it.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (w_push && (r_wptr == PtrW'(gi))) begin
                r_mem[gi] <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Pointers wrap explicitly so Depth need not be a power of two.
            if (w_push) begin
                r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/idma_r_burst_tracker.sv
// -----------------------------------------------------------------------------
// idma_r_burst_tracker
//   Tracks outstanding AXI read bursts so the R channel can be annotated with
//   "first beat of burst" and the owning request's decoupled flag. Throttles
//   the AR channel once NumAxInFlight bursts are outstanding and pulses err_o
//   on protocol violations.
//
//   Optional feature macro: IDMA_R_TRACKER_LAST_CHECK_EN
//     When defined, each entry also stores the burst length and a beat
//     counter checks that r_last arrives exactly on the final beat.
//
//   Parameters:
//     NumAxInFlight : maximum outstanding read bursts (2..64)
//     PrintFifoInfo : report the entry store configuration at elaboration
//
//   Ports:
//     clk_i, rst_i          : clock (rising edge), async active-high reset
//     testmode_i            : test mode, forwarded to the entry store
//     ar_valid_i/ar_ready_o : upstream AR handshake
//     ar_valid_o/ar_ready_i : downstream AR handshake
//     ar_len_i              : burst length (beats-1) of the presented AR
//     ar_decouple_aw_i      : presented AR belongs to a decoupled request
//     r_valid_i/r_ready_i   : observed R handshake
//     r_last_i              : observed R last flag
//     r_first_o             : current R beat is the first of its burst
//     r_decouple_aw_o       : decoupled flag of the burst owning the beat
//     err_o                 : one-cycle protocol error pulse
//     busy_o                : at least one burst outstanding
// -----------------------------------------------------------------------------
module idma_r_burst_tracker
    import idma_pkg::*;
#(
    parameter int unsigned NumAxInFlight = 2,
    parameter bit          PrintFifoInfo = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       testmode_i,
    input  logic       ar_valid_i,
    output logic       ar_ready_o,
    output logic       ar_valid_o,
    input  logic       ar_ready_i,
    input  logic [7:0] ar_len_i,
    input  logic       ar_decouple_aw_i,
    input  logic       r_valid_i,
    input  logic       r_ready_i,
    input  logic       r_last_i,
    output logic       r_first_o,
    output logic       r_decouple_aw_o,
    output logic       err_o,
    output logic       busy_o
);

`ifdef IDMA_R_TRACKER_LAST_CHECK_EN
    localparam int unsigned EntryW = RTrackEntryW;
`else
    localparam int unsigned EntryW = 1;
`endif

    logic              w_fifo_ready;
    logic              w_fifo_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_r_beat;
    logic              w_pop;
    logic              w_err_next;
    logic              w_head_decoupled;
    logic [EntryW-1:0] w_push_data;
    logic [EntryW-1:0] w_head_data;

    logic r_first;
    logic r_err;

    assign w_full  = ~w_fifo_ready;
    assign w_empty = ~w_fifo_valid;

    // Zero-latency pass-through of the AR handshake, blocked only while full.
    assign ar_valid_o = ar_valid_i & ~w_full;
    assign ar_ready_o = ar_ready_i & ~w_full;

    assign w_r_beat = r_valid_i & r_ready_i;
    assign w_pop    = w_r_beat & r_last_i & ~w_empty;

`ifdef IDMA_R_TRACKER_LAST_CHECK_EN
    r_track_entry_t w_push_entry;
    r_track_entry_t w_head_entry;
    axi_len_t       r_beat_cnt;
    logic           w_len_err;

    assign w_push_entry.len       = ar_len_i;
    assign w_push_entry.decoupled = ar_decouple_aw_i;
    assign w_push_data            = w_push_entry;
    assign w_head_entry           = w_head_data;
    assign w_head_decoupled       = w_head_entry.decoupled;

    // A last beat must land on the final count; a non-last beat must not.
    assign w_len_err = w_r_beat & ~w_empty &
                       (r_last_i ? (r_beat_cnt != w_head_entry.len)
                                 : (r_beat_cnt == w_head_entry.len));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_beat_cnt <= '0;
        end else if (w_r_beat) begin
            r_beat_cnt <= r_last_i ? '0 : r_beat_cnt + 1'b1;
        end
    end

    assign w_err_next = (w_r_beat & w_empty) | w_len_err;
`else
    logic [7:0] w_unused_ar_len;

    assign w_unused_ar_len  = ar_len_i;
    assign w_push_data      = ar_decouple_aw_i;
    assign w_head_decoupled = w_head_data[0];
    assign w_err_next       = w_r_beat & w_empty;
`endif

    idma_stream_fifo #(
        .Depth     ( NumAxInFlight ),
        .DataW     ( EntryW        ),
        .PrintInfo ( PrintFifoInfo )
    ) i_entry_store (
        .clk_i      ( clk_i                   ),
        .rst_i      ( rst_i                   ),
        .flush_i    ( 1'b0                    ),
        .testmode_i ( testmode_i              ),
        .data_i     ( w_push_data             ),
        .valid_i    ( ar_valid_i & ar_ready_i ),
        .ready_o    ( w_fifo_ready            ),
        .data_o     ( w_head_data             ),
        .valid_o    ( w_fifo_valid            ),
        .ready_i    ( w_pop                   )
    );

    // Any observed beat updates the first flag, even a stray one while empty,
    // so the beat after a last beat is always treated as a burst start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_first <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            if (w_r_beat) begin
                r_first <= r_last_i;
            end
            r_err <= w_err_next;
        end
    end

    assign r_first_o       = r_first & ~w_empty;
    assign r_decouple_aw_o = w_head_decoupled & ~w_empty;
    assign err_o           = r_err;
    assign busy_o          = ~w_empty;

endmodule
